uniq_cov_tracker: RTL and testbench

//  Parametrised, multi-channel hardware collector of unique {cmd,adr} coverage, placed beside the DUT bus monitor.

---
 rtl/uniq_cov_tracker.sv | 91 +++++++++
 tb/tb_uniq_cov_tracker.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uniq_cov_tracker.sv
// uniq_cov_tracker: per-channel or merged unique {cmd,adr} coverage bitmaps with sweep clear
module uniq_cov_tracker #(
  parameter int NCH = 2,
  parameter int CMD_W = 4,
  parameter int ADR_W = 4,
  parameter int MERGED = 0,
  localparam int BIN_W = CMD_W + ADR_W,
  localparam int BINS = 2 ** BIN_W,
  localparam int CNT_W = BIN_W + 1,
  localparam int NMAP = MERGED != 0 ? 1 : NCH,
  localparam int QW = NMAP > 1 ? $clog2(NMAP) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         valid,
  input  logic [NCH*CMD_W-1:0]   cmd,
  input  logic [NCH*ADR_W-1:0]   adr,
  input  logic                   clr_req,
  input  logic [QW-1:0]          q_map,
  input  logic [BIN_W-1:0]       q_bin,
  output logic                   q_hit,
  output logic [NMAP*CNT_W-1:0]  uniq_cnt,
  output logic [NCH-1:0]         new_hit,
  output logic [NMAP-1:0]        full,
  output logic [NCH-1:0]         dropped,
  output logic                   busy,
  output logic                   clr_done
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [BIN_W-1:0] idx;
  logic [BINS-1:0] map [NMAP];
  logic [BIN_W-1:0] bin [NCH];
  logic [NCH-1:0] nh;
  logic [CNT_W-1:0] cnt_n [NMAP];
  logic q_sel;
  logic accept;
  assign busy = state == CLEAR;
  assign accept = state == IDLE && !clr_req;
  // sweep runs to the last bin, then idles until a clear request
  always_comb state_n = busy ? (&idx ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
  // first-hit detection; in merged mode only the lowest channel on a shared new bin counts
  always_comb begin
    nh = '0;
    for (int i = 0; i < NCH; i++) bin[i] = {cmd[i*CMD_W +: CMD_W], adr[i*ADR_W +: ADR_W]};
    for (int i = 0; i < NCH; i++) begin
      nh[i] = accept && valid[i] && !map[MERGED != 0 ? 0 : i][bin[i]];
      for (int j = 0; j < NCH; j++)
        if (MERGED != 0 && j < i && valid[j] && bin[j] == bin[i]) nh[i] = 1'b0;
    end
  end
  // next unique counts and query bit select
  always_comb begin
    q_sel = 1'b0;
    for (int m = 0; m < NMAP; m++) begin
      cnt_n[m] = accept ? uniq_cnt[m*CNT_W +: CNT_W] : '0;
      for (int i = 0; i < NCH; i++)
        if ((MERGED != 0 ? 0 : i) == m) cnt_n[m] = cnt_n[m] + CNT_W'(nh[i]);
      if (q_map == QW'(m)) q_sel = map[m][q_bin];
    end
  end
  // bitmap storage is unreset; the sweep clears one bin per cycle in every map
  always_ff @(posedge clk) begin
    for (int m = 0; m < NMAP; m++) if (busy) map[m][idx] <= 1'b0;
    for (int i = 0; i < NCH; i++) if (nh[i]) map[MERGED != 0 ? 0 : i][bin[i]] <= 1'b1;
  end
  // state, sweep index, counters and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx <= '0;
      new_hit <= '0;
      dropped <= '0;
      clr_done <= 1'b0;
      q_hit <= 1'b0;
      uniq_cnt <= '0;
      full <= '0;
    end else begin
      state <= state_n;
      idx <= busy ? idx + BIN_W'(1) : '0;
      new_hit <= nh;
      dropped <= valid & {NCH{!accept}};
      clr_done <= busy && &idx;
      q_hit <= !busy && q_sel;
      for (int m = 0; m < NMAP; m++) begin
        uniq_cnt[m*CNT_W +: CNT_W] <= cnt_n[m];
        full[m] <= cnt_n[m] == CNT_W'(BINS);
      end
    end
  end
endmodule

// File: tb/tb_uniq_cov_tracker.sv
// tb_uniq_cov_tracker: directed checks of per-channel and merged coverage tracking
module tb_uniq_cov_tracker;
  logic clk = 0, rst = 0, clr_req = 0;
  logic [1:0] valid = 0;
  logic [7:0] cmd = 0, adr = 0, q_bin = 0;
  logic q_map = 0;
  logic p_q_hit, p_busy, p_clr_done, m_q_hit, m_busy, m_clr_done;
  logic [17:0] p_cnt;
  logic [8:0] m_cnt;
  logic [1:0] p_new, p_full, p_drop, m_new, m_drop;
  logic [0:0] m_full;
  int checks = 0, errors = 0, n = 0, hits = 0;
  logic [7:0] bv;

  always #5 clk = ~clk;

  uniq_cov_tracker dut_p (.clk(clk), .rst(rst), .valid(valid), .cmd(cmd), .adr(adr),
    .clr_req(clr_req), .q_map(q_map), .q_bin(q_bin), .q_hit(p_q_hit), .uniq_cnt(p_cnt),
    .new_hit(p_new), .full(p_full), .dropped(p_drop), .busy(p_busy), .clr_done(p_clr_done));

  uniq_cov_tracker #(.MERGED(1)) dut_m (.clk(clk), .rst(rst), .valid(valid), .cmd(cmd), .adr(adr),
    .clr_req(clr_req), .q_map(q_map), .q_bin(q_bin), .q_hit(m_q_hit), .uniq_cnt(m_cnt),
    .new_hit(m_new), .full(m_full), .dropped(m_drop), .busy(m_busy), .clr_done(m_clr_done));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    tick;
    rst = 0;
    chk("rst_busy", p_busy, 1);
    chk("rst_cnt", p_cnt, 0);
    chk("rst_new", p_new, 0);
    chk("rst_done", p_clr_done, 0);
    q_bin = 8'h35;
    n = 0;
    while (p_busy && n < 300) begin
      tick;
      n++;
      if (p_busy) chk("sweep_qhit", p_q_hit, 0);
    end
    chk("rst_sweep_len", n, 256);
    chk("rst_clr_done", p_clr_done, 1);
    chk("rst_m_busy", m_busy, 0);
    tick;
    chk("done_pulse", p_clr_done, 0);
    chk("rst_qhit", p_q_hit, 0);

    valid = 2'b11; cmd = 8'h11; adr = 8'h11;
    tick;
    chk("m_coll_new", m_new, 2'b01);
    chk("m_coll_cnt", m_cnt, 1);
    chk("p_coll_cnt", p_cnt, {9'd1, 9'd1});
    cmd = 8'h22; adr = 8'h32;
    tick;
    chk("m_pair_new", m_new, 2'b11);
    chk("m_pair_cnt", m_cnt, 3);
    chk("p_pair_cnt", p_cnt, {9'd2, 9'd2});
    valid = 0;
    tick;
    chk("m_new_pulse", m_new, 0);

    clr_req = 1; valid = 2'b01;
    tick;
    clr_req = 0;
    chk("clr_drop", p_drop, 2'b01);
    chk("clr_cnt", p_cnt, 0);
    chk("clr_m_cnt", m_cnt, 0);
    chk("clr_busy", p_busy, 1);
    valid = 2'b11;
    tick;
    valid = 0;
    chk("busy_drop", p_drop, 2'b11);
    chk("busy_m_drop", m_drop, 2'b11);
    n = 1;
    while (p_busy && n < 300) begin
      clr_req = n == 100;
      tick;
      n++;
    end
    clr_req = 0;
    chk("clr_sweep_len", n, 256);
    chk("clr_done", p_clr_done, 1);
    chk("clr_idle_drop", p_drop, 0);
    q_map = 0; q_bin = 8'h11;
    tick;
    chk("clr_qhit", p_q_hit, 0);
    chk("clr_m_qhit", m_q_hit, 0);

    q_bin = 8'h35; valid = 2'b01; cmd = 8'h03; adr = 8'h05;
    tick;
    chk("first_new", p_new, 2'b01);
    chk("first_cnt", p_cnt, {9'd0, 9'd1});
    chk("q_same_edge", p_q_hit, 0);
    tick;
    chk("rehit_new", p_new, 0);
    chk("q_after", p_q_hit, 1);
    tick;
    chk("rehit2_new", p_new, 0);
    adr = 8'h06;
    tick;
    chk("second_new", p_new, 2'b01);
    chk("t2_cnt", p_cnt, {9'd0, 9'd2});
    valid = 0; q_map = 1;
    tick;
    chk("q_other_map", p_q_hit, 0);
    chk("idle_new", p_new, 0);

    hits = 0;
    for (int b = 0; b < 256; b++) begin
      bv = b[7:0];
      valid = 2'b10; cmd = {bv[7:4], 4'h0}; adr = {bv[3:0], 4'h0};
      tick;
      hits += int'(p_new[1]);
      if (b == 254) begin
        chk("near_full_cnt", p_cnt[17:9], 255);
        chk("near_full", p_full, 0);
      end
    end
    chk("sweep_hits", hits, 256);
    chk("full_cnt", p_cnt[17:9], 256);
    chk("full_flag", p_full, 2'b10);
    cmd = 0; adr = 0;
    tick;
    chk("repeat_new", p_new, 0);
    chk("repeat_cnt", p_cnt, {9'd256, 9'd2});
    chk("repeat_full", p_full, 2'b10);
    valid = 0; q_map = 1; q_bin = 8'hAB;
    tick;
    chk("q_full_map", p_q_hit, 1);
    q_map = 0; q_bin = 8'h36;
    tick;
    chk("q_map0", p_q_hit, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
